// File: rtl/vga_timing_ctrl_if.sv
// vga_timing_ctrl_if: raster bus; i_En into the sequencer, scan counters, syncs, active qualifier and line/frame strobes out
interface vga_timing_ctrl_if;
  logic       i_En;
  logic [9:0] o_Col_Num;
  logic [9:0] o_Row_Num;
  logic       o_Hsync;
  logic       o_Vsync;
  logic       o_Active;
  logic       o_Line_Start;
  logic       o_Frame_Start;
  modport master (
    input  i_En,
    output o_Col_Num, o_Row_Num, o_Hsync, o_Vsync, o_Active, o_Line_Start, o_Frame_Start
  );
  modport slave (
    output i_En,
    input  o_Col_Num, o_Row_Num, o_Hsync, o_Vsync, o_Active, o_Line_Start, o_Frame_Start
  );
endinterface

// File: rtl/vga_timing_ctrl.sv
// vga_timing_ctrl: VGA raster sequencer; ports i_Clk, i_Reset (sync, active-high), bus.master (i_En in; col/row, Hsync/Vsync, Active, Line/Frame strobes out)
module vga_timing_ctrl #(
  parameter int TOTAL_COLS    = 800,
  parameter int TOTAL_ROWS    = 525,
  parameter int ACTIVE_COLS   = 640,
  parameter int ACTIVE_ROWS   = 480,
  parameter int H_FRONT_PORCH = 18,
  parameter int H_BACK_PORCH  = 50,
  parameter int V_FRONT_PORCH = 10,
  parameter int V_BACK_PORCH  = 33
) (
  input  logic              i_Clk,
  input  logic              i_Reset,
  vga_timing_ctrl_if.master bus
);
  localparam int HS = ACTIVE_COLS + H_FRONT_PORCH;
  localparam int HE = TOTAL_COLS - H_BACK_PORCH;
  localparam int VS = ACTIVE_ROWS + V_FRONT_PORCH;
  localparam int VE = TOTAL_ROWS - V_BACK_PORCH;
  if (TOTAL_COLS > 1024 || TOTAL_ROWS > 1024 || HE - HS < 1 || VE - VS < 1) begin : g_bad_params
    $error("vga_timing_ctrl: totals must be <= 1024 and each sync width >= 1");
  end
  typedef enum logic [1:0] {ACTIVE, FRONT, SYNC, BACK} phase_t;
  // Phase transitions fire on the boundary value of the next counter; later phases are tested first so a zero-width porch still lands in the right phase.
  function automatic phase_t nxt(phase_t cur, logic [9:0] n, int a, int s, int e);
    logic [10:0] w;
    w = {1'b0, n};
    return w == 11'(e) ? BACK : w == 11'(s) ? SYNC : w == 11'(a) ? FRONT : n == '0 ? ACTIVE : cur;
  endfunction
  logic [9:0] col_q, col_d, row_q, row_d;
  phase_t     h_q, h_d, v_q, v_d;
  logic       wrap, hs_q, vs_q, act_q, ls_q, fs_q;
  always_comb begin
    wrap  = col_q == 10'(TOTAL_COLS - 1);
    col_d = wrap ? '0 : col_q + 10'd1;
    row_d = !wrap ? row_q : row_q == 10'(TOTAL_ROWS - 1) ? '0 : row_q + 10'd1;
    h_d   = nxt(h_q, col_d, ACTIVE_COLS, HS, HE);
    v_d   = nxt(v_q, row_d, ACTIVE_ROWS, VS, VE);
  end
  // Outputs are decoded from next-state values so they align with the counters they are registered alongside.
  always_ff @(posedge i_Clk)
    if (i_Reset) begin
      col_q <= 10'(TOTAL_COLS - 1);
      row_q <= 10'(TOTAL_ROWS - 1);
      h_q   <= BACK;
      v_q   <= BACK;
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
      act_q <= 1'b0;
      ls_q  <= 1'b0;
      fs_q  <= 1'b0;
    end else begin
      ls_q <= 1'b0;
      fs_q <= 1'b0;
      if (bus.i_En) begin
        col_q <= col_d;
        row_q <= row_d;
        h_q   <= h_d;
        v_q   <= v_d;
        hs_q  <= h_d != SYNC;
        vs_q  <= v_d != SYNC;
        act_q <= h_d == ACTIVE && v_d == ACTIVE;
        ls_q  <= wrap;
        fs_q  <= wrap && row_d == '0;
      end
    end
  assign bus.o_Col_Num     = col_q;
  assign bus.o_Row_Num     = row_q;
  assign bus.o_Hsync       = hs_q;
  assign bus.o_Vsync       = vs_q;
  assign bus.o_Active      = act_q;
  assign bus.o_Line_Start  = ls_q;
  assign bus.o_Frame_Start = fs_q;
endmodule

// File: tb/tb_vga_timing_ctrl.sv
// tb_vga_timing_ctrl: checks a default-size raster and a scaled-down raster (whole frames cheaply) against a range-decoding model
module tb_vga_timing_ctrl;
  typedef struct packed {
    logic [9:0] col;
    logic [9:0] row;
    logic       hs, vs, act, ls, fs;
  } out_t;
  typedef struct {
    logic rst, en;
    out_t exp;
  } vec_t;
  logic clk = 1'b0, rst = 1'b1, en = 1'b0;
  int vectors = 0, miscompares = 0;
  out_t m_d = '0, m_s = '0, last_d, last_s, got_d, got_s;
  out_t q_d[$], q_s[$];
  vec_t tbl[8];
  vga_timing_ctrl_if bus_d ();
  vga_timing_ctrl_if bus_s ();
  assign bus_d.i_En = en;
  assign bus_s.i_En = en;
  vga_timing_ctrl dut_d (.i_Clk(clk), .i_Reset(rst), .bus(bus_d));
  vga_timing_ctrl #(
    .TOTAL_COLS(40), .TOTAL_ROWS(20), .ACTIVE_COLS(24), .ACTIVE_ROWS(12),
    .H_FRONT_PORCH(4), .H_BACK_PORCH(6), .V_FRONT_PORCH(2), .V_BACK_PORCH(4)
  ) dut_s (.i_Clk(clk), .i_Reset(rst), .bus(bus_s));
  assign got_d = {bus_d.o_Col_Num, bus_d.o_Row_Num, bus_d.o_Hsync, bus_d.o_Vsync, bus_d.o_Active, bus_d.o_Line_Start, bus_d.o_Frame_Start};
  assign got_s = {bus_s.o_Col_Num, bus_s.o_Row_Num, bus_s.o_Hsync, bus_s.o_Vsync, bus_s.o_Active, bus_s.o_Line_Start, bus_s.o_Frame_Start};
  always #5 clk = ~clk;
  function automatic out_t model(logic r, logic e, out_t cur, int tc, int tr, int ac, int ar, int hf, int hb, int vf, int vb);
    out_t n;
    int c, w;
    c = int'(cur.col);
    w = int'(cur.row);
    if (r) begin
      c = tc - 1;
      w = tr - 1;
    end else if (e) begin
      c = (c == tc - 1) ? 0 : c + 1;
      if (c == 0) w = (w == tr - 1) ? 0 : w + 1;
    end
    n.col = 10'(c);
    n.row = 10'(w);
    n.hs  = !(c >= ac + hf && c < tc - hb);
    n.vs  = !(w >= ar + vf && w < tr - vb);
    n.act = c < ac && w < ar;
    n.ls  = !r && e && c == 0;
    n.fs  = n.ls && w == 0;
    return n;
  endfunction
  task automatic cmp(string nm, out_t g, out_t x);
    vectors++;
    if (g !== x) begin
      miscompares++;
      $display("FAIL %s: got col=%0d row=%0d hs=%b vs=%b act=%b ls=%b fs=%b, expected col=%0d row=%0d hs=%b vs=%b act=%b ls=%b fs=%b",
               nm, g.col, g.row, g.hs, g.vs, g.act, g.ls, g.fs, x.col, x.row, x.hs, x.vs, x.act, x.ls, x.fs);
    end
  endtask
  task automatic chk(string nm, int g, int x);
    vectors++;
    if (g != x) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", nm, g, x);
    end
  endtask
  task automatic step(logic r, logic e);
    rst = r;
    en  = e;
    m_d = model(r, e, m_d, 800, 525, 640, 480, 18, 50, 10, 33);
    m_s = model(r, e, m_s, 40, 20, 24, 12, 4, 6, 2, 4);
    q_d.push_back(m_d);
    q_s.push_back(m_s);
    @(posedge clk);
    #1;
    last_d = got_d;
    last_s = got_s;
    cmp("raster_default", last_d, q_d.pop_front());
    cmp("raster_small", last_s, q_s.pop_front());
  endtask
  initial begin
    int a, h, l, f, v, b, s;
    tbl[0] = '{1'b1, 1'b1, {10'd799, 10'd524, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}};
    tbl[1] = '{1'b1, 1'b1, {10'd799, 10'd524, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}};
    tbl[2] = '{1'b1, 1'b1, {10'd799, 10'd524, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}};
    tbl[3] = '{1'b0, 1'b1, {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1}};
    tbl[4] = '{1'b0, 1'b0, {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0}};
    tbl[5] = '{1'b0, 1'b1, {10'd1, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0}};
    tbl[6] = '{1'b0, 1'b1, {10'd2, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0}};
    tbl[7] = '{1'b1, 1'b0, {10'd799, 10'd524, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}};
    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].en);
      cmp($sformatf("table_%0d", i), last_d, tbl[i].exp);
    end
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0);
    chk("stall_col", int'(last_d.col), 799);
    step(1'b0, 1'b1);
    chk("resume_strobes", int'({last_d.ls, last_d.fs, last_s.ls, last_s.fs}), 15);
    a = int'(last_d.act);
    h = int'(!last_d.hs);
    l = int'(last_d.ls);
    for (int i = 0; i < 799; i++) begin
      step(1'b0, 1'b1);
      a += int'(last_d.act);
      h += int'(!last_d.hs);
      l += int'(last_d.ls);
    end
    chk("line_active_cols", a, 640);
    chk("line_hsync_low", h, 92);
    chk("line_starts", l, 1);
    step(1'b0, 1'b1);
    chk("row_after_line", int'(last_d.row), 1);
    step(1'b1, 1'b0);
    f = 0;
    v = 0;
    b = 0;
    for (int i = 0; i < 2400; i++) begin
      step(1'b0, 1'b1);
      f += int'(last_s.fs);
      v += int'(!last_s.vs);
      b += int'(last_s.act && last_s.row >= 10'd12);
    end
    chk("small_frame_starts", f, 3);
    chk("small_vsync_low", v, 240);
    chk("small_active_blank_rows", b, 0);
    step(1'b1, 1'b0);
    h = 0;
    s = 0;
    for (int i = 0; i < 3200; i++) begin
      step(1'b0, i % 2 == 0);
      h += int'(en && !last_d.hs);
      s += int'(!en && (last_d.ls || last_d.fs || last_s.ls || last_s.fs));
    end
    chk("alt_hsync_low", h, 184);
    chk("alt_stall_strobes", s, 0);
    step(1'b1, 1'b0);
    for (int i = 0; i < 211; i++) step(1'b0, 1'b1);
    chk("mid_frame_pos", int'({last_s.col, last_s.row, last_s.act}), int'({10'd10, 10'd5, 1'b1}));
    step(1'b1, 1'b1);
    chk("mid_reset_small", int'({last_s.col, last_s.row, last_s.hs, last_s.vs, last_s.act}), int'({10'd39, 10'd19, 3'b110}));
    step(1'b0, 1'b1);
    chk("restart_frame", int'({last_d.fs, last_s.fs}), 3);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/vga_timing_ctrl.md
Name: vga_timing_ctrl

Overview:
- Master VGA raster sequencer. Generates the column/row scan counters plus porch-correct, active-low Hsync/Vsync, the active-video qualifier and frame/line start strobes.
- Each axis runs its own four-phase state machine: ACTIVE -> FRONT -> SYNC -> BACK.
- Sits at the head of the video pipeline. Drives the pixel generators (paddles, ball, score) and the VGA output stage.
- Pauses cleanly on an enable so the rest of the game logic can stall the raster.

Parameters:
- TOTAL_COLS, 800, pixels per line including blanking
- TOTAL_ROWS, 525, lines per frame including blanking
- ACTIVE_COLS, 640, visible pixels per line
- ACTIVE_ROWS, 480, visible lines per frame
- H_FRONT_PORCH, 18, columns between end of active video and start of Hsync
- H_BACK_PORCH, 50, columns between end of Hsync and end of line
- V_FRONT_PORCH, 10, rows between end of active video and start of Vsync
- V_BACK_PORCH, 33, rows between end of Vsync and end of frame

Ports:
- i_Clk  input  1  pixel clock
- i_Reset  input  1  synchronous, active-high reset
- i_En  input  1  advance raster by one pixel when high; hold all state when low
- o_Col_Num  output  10  current column, 0..TOTAL_COLS-1
- o_Row_Num  output  10  current row, 0..TOTAL_ROWS-1
- o_Hsync  output  1  active-low horizontal sync
- o_Vsync  output  1  active-low vertical sync
- o_Active  output  1  high when column < ACTIVE_COLS and row < ACTIVE_ROWS
- o_Line_Start  output  1  one-cycle strobe, column just wrapped to 0
- o_Frame_Start  output  1  one-cycle strobe, column and row just wrapped to (0,0)

Behaviour:
- All outputs are registers updated on posedge i_Clk. Within any cycle, every output corresponds to the same (col,row) pair; there is no skew between counters and decoded signals.
- Reset is synchronous and has priority over i_En. It forces:
  - col=TOTAL_COLS-1 (799), row=TOTAL_ROWS-1 (524)
  - H state BACK, V state BACK
  - o_Hsync=1, o_Vsync=1, o_Active=0, o_Line_Start=0, o_Frame_Start=0
- Consequently the first enabled edge after reset lands on (0,0) with o_Frame_Start=1.
- Column counter, on an enabled edge: increments by 1; at TOTAL_COLS-1 it wraps to 0.
- Row counter: increments only on an enabled edge where col wraps. At TOTAL_ROWS-1 it wraps to 0 in the same edge.
- H state machine (next state decoded from next column):
  - ACTIVE: col 0..ACTIVE_COLS-1
  - FRONT: next H_FRONT_PORCH columns
  - SYNC: columns ACTIVE_COLS+H_FRONT_PORCH .. TOTAL_COLS-H_BACK_PORCH-1
  - BACK: last H_BACK_PORCH columns
  - Defaults: FRONT 640..657, SYNC 658..749 (92 cols), BACK 750..799.
- V state machine: same structure on rows, advancing only at column wrap.
  - Defaults: FRONT 480..489, SYNC 490..491, BACK 492..524.
- o_Hsync=0 iff H state is SYNC. o_Vsync=0 iff V state is SYNC. Vsync is held for whole lines, including the blanking columns of those lines.
- o_Active=1 iff H state is ACTIVE and V state is ACTIVE.
- o_Line_Start=1 for exactly the enabled edge that produces col=0. o_Frame_Start=1 only when that same edge also produces row=0.
- i_En low: counters, states and sync/active outputs hold their values; both strobes are forced to 0 on that edge. A strobe is never repeated while the raster is stalled.
- i_En toggling every cycle: the raster advances one pixel per enabled edge. Timing in pixel counts is unchanged.
- Reset mid-frame: the next edge returns to the reset values above, regardless of state or i_En.
- Widths: counters are 10 bits. TOTAL_COLS and TOTAL_ROWS must be <= 1024. Each sync width, computed as TOTAL - ACTIVE - FRONT - BACK, must be >= 1. The implementation includes an elaboration-time check for these constraints.
- No combinational path from any input to any output.

Test Plan:
- Reset held 3 cycles, then i_En=1 -> reset values on each reset cycle, then first edge gives (0,0), o_Frame_Start=1, o_Line_Start=1, o_Active=1.
- Free run one full line -> o_Active high cols 0..639; o_Hsync low exactly cols 658..749 (92 cycles); o_Line_Start only at col 0; row increments 0->1 at the 800th edge.
- Free run one full frame (420000 edges) -> o_Vsync low exactly rows 490..491 (1600 cycles); o_Active=0 for all rows >= 480; exactly one o_Frame_Start per 420000 enabled edges.
- i_En deasserted for 5 cycles at col 799 row 524 -> all outputs frozen; no strobes while stalled; re-enable gives (0,0) with both strobes on that single edge.
- i_En alternating 1/0 for 2 lines -> Hsync low for 92 enabled edges per line; strobe pulses are 1 cycle wide and never coincide with i_En=0.
- Reset asserted at (300,200) during active video -> next edge col=799, row=524, o_Active=0, o_Hsync=1, o_Vsync=1; resumes at (0,0) with o_Frame_Start=1.
